lcd_hd44780_rx: RTL and testbench

HD44780-compatible 4-bit-interface receiver. It is the responder end of the character-LCD bus driven by the team's LCD writer. It samples LCD_E/RS/RW/DB[7:4], assembles nibbles into bytes, executes the command set into an internal DDRAM and cursor/display state, and exposes DDRAM through a read port. It serves as an on-chip loopback checker and as a synthesizable display model for the LCD UI path.

---
 rtl/lcd_pkg.sv | 65 ++++++
 rtl/lcd_hd44780_rx_if.sv | 36 +++
 rtl/lcd_ddram.sv | 41 ++++
 rtl/lcd_hd44780_rx.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_hd44780_rx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-compatible receiver:
//   - command opcode masks (leading-one decode order)
//   - DDRAM line bounds and blank character
//   - busy intervals in microseconds and a cycle conversion helper
//   - receiver state encoding
//   - address-counter step and DDRAM address mapping helpers
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    localparam logic [6:0] LINE0_END  = 7'h27;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h67;

    localparam int         DDRAM_DEPTH = 80;
    localparam logic [6:0] CLR_LAST    = 7'd79;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    localparam int BUSY_LONG_US  = 1520;
    localparam int BUSY_SHORT_US = 40;

    typedef logic [1:0] lcd_state_t;
    localparam lcd_state_t S_8BIT = 2'd0;
    localparam lcd_state_t S_HI   = 2'd1;
    localparam lcd_state_t S_LO   = 2'd2;
    localparam lcd_state_t S_CLR  = 2'd3;

    // Divide first so CLK_HZ * 1520 never overflows 32 bits.
    function automatic logic [31:0] us_to_cycles(input int clk_hz, input int us);
        return 32'((clk_hz / 1000) * us / 1000);
    endfunction

    function automatic logic ddram_addr_ok(input logic [6:0] a);
        return (a <= LINE0_END) || ((a >= LINE1_BASE) && (a <= LINE1_END));
    endfunction

    // Line 1 is packed directly after the 40 bytes of line 0.
    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    endfunction

    // Address counter step with the two-line wrap points.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == LINE0_END)       return LINE1_BASE;
            else if (ac == LINE1_END)  return 7'h00;
            else                       return ac + 7'd1;
        end else begin
            if (ac == 7'h00)           return LINE1_END;
            else if (ac == LINE1_BASE) return LINE0_END;
            else                       return ac - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_hd44780_rx_if.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_rx_if
// Bundles the LCD bus, the DDRAM read port and the receiver status outputs.
//   slave  : the receiver (samples LCD_*, rd_addr; drives status/rd_data)
//   master : the bus driver / observer
// ---------------------------------------------------------------------------
interface lcd_hd44780_rx_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [3:0] LCD_DB;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_valid;
    logic       data_valid;
    logic [7:0] rx_byte;
    logic [6:0] cursor_addr;
    logic       mode4;
    logic       disp_on;
    logic       cur_on;
    logic       blink_on;
    logic       busy;
    logic       err_busy;

    modport slave (
        input  LCD_E, LCD_RS, LCD_RW, LCD_DB, rd_addr,
        output rd_data, cmd_valid, data_valid, rx_byte, cursor_addr,
               mode4, disp_on, cur_on, blink_on, busy, err_busy
    );

    modport master (
        output LCD_E, LCD_RS, LCD_RW, LCD_DB, rd_addr,
        input  rd_data, cmd_valid, data_valid, rx_byte, cursor_addr,
               mode4, disp_on, cur_on, blink_on, busy, err_busy
    );
endinterface

// File: rtl/lcd_ddram.sv
// ---------------------------------------------------------------------------
// lcd_ddram
// 80x8 display data RAM. Linear index = addr[6]*40 + addr[5:0].
//   clk, rst          : clock, async active-high reset (read register only)
//   wr_en/addr/data   : byte write at a DDRAM address (AC domain)
//   clr_en/clr_idx    : clear-sweep write of the blank char at a linear index
//   rd_addr/rd_data   : registered read, 1-cycle latency; holes read blank
// ---------------------------------------------------------------------------
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr_en,
    input  logic [6:0] clr_idx,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [0:DDRAM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (clr_en)
            mem[clr_idx] <= BLANK_CHAR;
        else if (wr_en)
            mem[ddram_index(wr_addr)] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (ddram_addr_ok(rd_addr))
            rd_data <= mem[ddram_index(rd_addr)];
        else
            rd_data <= BLANK_CHAR;
    end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_rx
// HD44780-compatible receiver: samples the LCD bus, assembles 8-bit or
// 4-bit (two-nibble) transfers into bytes, executes commands/data into a
// DDRAM and cursor/display state, and exposes DDRAM through a read port.
//   CLK_50M : system clock
//   reset   : asynchronous active-high reset
//   bus     : lcd_hd44780_rx_if.slave (LCD_E/RS/RW/DB in, read port,
//             cmd_valid/data_valid pulses, rx_byte, cursor_addr, mode4,
//             disp_on/cur_on/blink_on, busy, err_busy)
// Build option: define LCD_RX_BUSY_EN to model the busy intervals and drop
// writes that arrive while busy; otherwise busy is tied low.
// ---------------------------------------------------------------------------
module lcd_hd44780_rx
    import lcd_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
)(
    input logic              CLK_50M,
    input logic              reset,
    lcd_hd44780_rx_if.slave  bus
);

    localparam logic [31:0] BUSY_LONG  = us_to_cycles(CLK_HZ, BUSY_LONG_US);
    localparam logic [31:0] BUSY_SHORT = us_to_cycles(CLK_HZ, BUSY_SHORT_US);

    // ---- stage p0/p1: registered bus and its previous value ----
    logic       e_p0, rs_p0, rw_p0;
    logic [3:0] db_p0;
    logic       e_p1, rs_p1, rw_p1;
    logic [3:0] db_p1;

    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            e_p0  <= 1'b0;
            rs_p0 <= 1'b0;
            rw_p0 <= 1'b0;
            db_p0 <= 4'h0;
            e_p1  <= 1'b0;
            rs_p1 <= 1'b0;
            rw_p1 <= 1'b0;
            db_p1 <= 4'h0;
        end else begin
            e_p0  <= bus.LCD_E;
            rs_p0 <= bus.LCD_RS;
            rw_p0 <= bus.LCD_RW;
            db_p0 <= bus.LCD_DB;
            e_p1  <= e_p0;
            rs_p1 <= rs_p0;
            rw_p1 <= rw_p0;
            db_p1 <= db_p0;
        end
    end

    logic fall;
    assign fall = e_p1 & ~e_p0;

    lcd_state_t state;
    logic [3:0] hi_nib;
    logic       hi_rs, hi_rw;
    logic       ex_vld, ex_rs;
    logic [7:0] ex_byte;
    logic [6:0] ac;
    logic       id;
    logic       disp_on, cur_on, blink_on;
    logic       mode4;
    logic       err_busy;
    logic [6:0] clr_idx;
    logic       blocked;

`ifdef LCD_RX_BUSY_EN
    logic [31:0] busy_cnt;
    logic        long_cmd;

    assign long_cmd = ~ex_rs
                    && ((ex_byte & ~(OP_HOME | OP_CLEAR)) == 8'h00)
                    && ((ex_byte &  (OP_HOME | OP_CLEAR)) != 8'h00);

    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset)
            busy_cnt <= '0;
        else if (ex_vld)
            busy_cnt <= long_cmd ? BUSY_LONG : BUSY_SHORT;
        else if (busy_cnt != 32'd0)
            busy_cnt <= busy_cnt - 32'd1;
    end

    // The last busy cycle already accepts a new transfer; reads always pass.
    assign blocked  = (busy_cnt > 32'd1) && ~rw_p1;
    assign bus.busy = (busy_cnt != 32'd0);
`else
    logic unused_busy_cfg;
    assign unused_busy_cfg = ^{BUSY_LONG, BUSY_SHORT};
    assign blocked  = 1'b0;
    assign bus.busy = 1'b0;
`endif

    logic drop, take;
    assign drop = fall & ((state == S_CLR) | blocked);
    assign take = fall & ~drop;

    // ---- stage p2: byte assembly on fall, execute one cycle later ----
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            state    <= S_8BIT;
            hi_nib   <= 4'h0;
            hi_rs    <= 1'b0;
            hi_rw    <= 1'b0;
            ex_vld   <= 1'b0;
            ex_rs    <= 1'b0;
            ex_byte  <= 8'h00;
            ac       <= 7'h00;
            id       <= 1'b1;
            disp_on  <= 1'b0;
            cur_on   <= 1'b0;
            blink_on <= 1'b0;
            mode4    <= 1'b0;
            err_busy <= 1'b0;
            clr_idx  <= 7'd0;
        end else begin
            ex_vld <= 1'b0;

            if (drop)
                err_busy <= 1'b1;

            if (take) begin
                case (state)
                    S_8BIT: begin
                        if (!rw_p1) begin
                            ex_vld  <= 1'b1;
                            ex_rs   <= rs_p1;
                            ex_byte <= {db_p1, 4'h0};
                        end
                    end
                    S_HI: begin
                        hi_nib <= db_p1;
                        hi_rs  <= rs_p1;
                        hi_rw  <= rw_p1;
                        state  <= S_LO;
                    end
                    S_LO: begin
                        // A read on either half keeps the phase moving but executes nothing.
                        if (!(hi_rw | rw_p1)) begin
                            ex_vld  <= 1'b1;
                            ex_rs   <= hi_rs;
                            ex_byte <= {hi_nib, db_p1};
                        end
                        state <= S_HI;
                    end
                    default: ;
                endcase
            end

            if (ex_vld) begin
                if (ex_rs) begin
                    ac <= ac_step(ac, id);
                end else if (|(ex_byte & OP_DDRAM)) begin
                    ac <= ddram_addr_ok(ex_byte[6:0]) ? ex_byte[6:0] : 7'h00;
                end else if (|(ex_byte & OP_CGRAM)) begin
                    // CGRAM addressing is accepted without effect.
                end else if (|(ex_byte & OP_FUNC)) begin
                    if (!ex_byte[4] && state == S_8BIT) begin
                        state <= S_HI;
                        mode4 <= 1'b1;
                    end else if (ex_byte[4] && state == S_HI) begin
                        state <= S_8BIT;
                        mode4 <= 1'b0;
                    end
                end else if (|(ex_byte & OP_SHIFT)) begin
                    if (!ex_byte[3])
                        ac <= ac_step(ac, ex_byte[2]);
                end else if (|(ex_byte & OP_DISPLAY)) begin
                    {disp_on, cur_on, blink_on} <= ex_byte[2:0];
                end else if (|(ex_byte & OP_ENTRY)) begin
                    id <= ex_byte[1];
                end else if (|(ex_byte & OP_HOME)) begin
                    ac <= 7'h00;
                end else if (|(ex_byte & OP_CLEAR)) begin
                    ac      <= 7'h00;
                    id      <= 1'b1;
                    clr_idx <= 7'd0;
                    state   <= S_CLR;
                end
            end

            if (state == S_CLR) begin
                clr_idx <= clr_idx + 7'd1;
                if (clr_idx == CLR_LAST)
                    state <= mode4 ? S_HI : S_8BIT;
            end
        end
    end

    lcd_ddram u_ddram (
        .clk     (CLK_50M),
        .rst     (reset),
        .wr_en   (ex_vld & ex_rs),
        .wr_addr (ac),
        .wr_data (ex_byte),
        .clr_en  (state == S_CLR),
        .clr_idx (clr_idx),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

    assign bus.cmd_valid   = ex_vld & ~ex_rs;
    assign bus.data_valid  = ex_vld &  ex_rs;
    assign bus.rx_byte     = ex_byte;
    assign bus.cursor_addr = ac;
    assign bus.mode4       = mode4;
    assign bus.disp_on     = disp_on;
    assign bus.cur_on      = cur_on;
    assign bus.blink_on    = blink_on;
    assign bus.err_busy    = err_busy;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// ---------------------------------------------------------------------------
// tb_lcd_hd44780_rx
// Directed bench for lcd_hd44780_rx: drives LCD bus transfers and checks
// mode, cursor, display bits, pulses and DDRAM contents against
// hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_hd44780_rx;

`ifdef LCD_RX_BUSY_EN
    localparam int TB_CLK_HZ = 5_000_000;
`else
    localparam int TB_CLK_HZ = 50_000_000;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_hd44780_rx_if lcd_bus();

    lcd_hd44780_rx #(.CLK_HZ(TB_CLK_HZ)) dut (
        .CLK_50M (clk),
        .reset   (rst),
        .bus     (lcd_bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cv_cnt = 0;
    int dv_cnt = 0;

    always @(negedge clk) begin
        if (lcd_bus.cmd_valid  === 1'b1) cv_cnt++;
        if (lcd_bus.data_valid === 1'b1) dv_cnt++;
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (lcd_bus.busy === 1'b1 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (lcd_bus.busy !== 1'b0)
            expect_eq("busy_timeout", 32'(lcd_bus.busy), 32'd0);
    endtask

    task automatic nib(input logic rs, input logic rw, input logic [3:0] d, input bit wait_rdy);
        if (wait_rdy) wait_ready();
        @(posedge clk); #1;
        lcd_bus.LCD_RS = rs;
        lcd_bus.LCD_RW = rw;
        lcd_bus.LCD_DB = d;
        lcd_bus.LCD_E  = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_bus.LCD_E = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wr4(input logic rs, input logic [7:0] b);
        nib(rs, 1'b0, b[7:4], 1'b1);
        nib(rs, 1'b0, b[3:0], 1'b1);
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk);
        lcd_bus.rd_addr = a;
        @(negedge clk);
        d = lcd_bus.rd_data;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int bad, c0, d0;

        lcd_bus.LCD_E = 1'b0; lcd_bus.LCD_RS = 1'b0; lcd_bus.LCD_RW = 1'b0;
        lcd_bus.LCD_DB = 4'h0; lcd_bus.rd_addr = 7'h00;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        expect_eq("rst_mode4",   32'(lcd_bus.mode4),       0);
        expect_eq("rst_ac",      32'(lcd_bus.cursor_addr), 0);
        expect_eq("rst_dcb",     32'({lcd_bus.disp_on, lcd_bus.cur_on, lcd_bus.blink_on}), 0);
        expect_eq("rst_busy",    32'({lcd_bus.busy, lcd_bus.err_busy}), 0);
        expect_eq("rst_pulses",  32'({lcd_bus.cmd_valid, lcd_bus.data_valid}), 0);
        expect_eq("rst_rx_byte", 32'(lcd_bus.rx_byte), 0);
        expect_eq("rst_rd_data", 32'(lcd_bus.rd_data), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Init: 8-bit 3,3,3,2 then 4-bit 0x28 0x06 0x0C 0x01
        c0 = cv_cnt;
        nib(0, 0, 4'h3, 1); nib(0, 0, 4'h3, 1); nib(0, 0, 4'h3, 1); nib(0, 0, 4'h2, 1);
        expect_eq("init_mode4_after_2", 32'(lcd_bus.mode4), 1);
        wr4(0, 8'h28); wr4(0, 8'h06); wr4(0, 8'h0C); wr4(0, 8'h01);
        repeat (100) @(posedge clk);
        wait_ready();
        expect_eq("init_cmd_pulses", 32'(cv_cnt - c0), 8);
        expect_eq("init_mode4",      32'(lcd_bus.mode4), 1);
        expect_eq("init_dcb",        32'({lcd_bus.disp_on, lcd_bus.cur_on, lcd_bus.blink_on}), 32'b100);
        expect_eq("init_ac",         32'(lcd_bus.cursor_addr), 0);
        expect_eq("init_rx_byte",    32'(lcd_bus.rx_byte), 32'h01);
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            rd(7'(a), d);
            if (d !== 8'h20) bad++;
        end
        expect_eq("clear_fill_bad", 32'(bad), 0);

        // Two data bytes
        d0 = dv_cnt;
        wr4(1, 8'h30); wr4(1, 8'h31);
        expect_eq("data_pulses", 32'(dv_cnt - d0), 2);
        expect_eq("data_ac", 32'(lcd_bus.cursor_addr), 32'h02);
        rd(7'h00, d); expect_eq("ddram_00", 32'(d), 32'h30);
        rd(7'h01, d); expect_eq("ddram_01", 32'(d), 32'h31);

        // Read transfer pair keeps nibble alignment and executes nothing
        c0 = cv_cnt; d0 = dv_cnt;
        nib(0, 1, 4'hF, 1); nib(0, 1, 4'hF, 1);
        expect_eq("rw_no_pulse", 32'((cv_cnt - c0) + (dv_cnt - d0)), 0);
        wr4(1, 8'h32);
        rd(7'h02, d); expect_eq("rw_align_ddram_02", 32'(d), 32'h32);
        expect_eq("rw_align_ac", 32'(lcd_bus.cursor_addr), 32'h03);

        // Line wrap on increment
        wr4(0, 8'hA7); wr4(1, 8'h41); wr4(1, 8'h41);
        rd(7'h27, d); expect_eq("ddram_27", 32'(d), 32'h41);
        rd(7'h40, d); expect_eq("ddram_40", 32'(d), 32'h41);
        expect_eq("wrap_ac_41", 32'(lcd_bus.cursor_addr), 32'h41);
        rd(7'h28, d); expect_eq("rd_out_of_range_28", 32'(d), 32'h20);

        // Decrement wrap from 0x00
        wr4(0, 8'h02); wr4(0, 8'h04); wr4(1, 8'h5A);
        rd(7'h00, d); expect_eq("ddram_00_dec", 32'(d), 32'h5A);
        expect_eq("dec_wrap_ac", 32'(lcd_bus.cursor_addr), 32'h67);

        // Increment wrap 0x67 -> 0x00, bad set-address, cursor shifts, display bits
        wr4(0, 8'h06); wr4(0, 8'hE7); wr4(1, 8'h7E);
        rd(7'h67, d); expect_eq("ddram_67", 32'(d), 32'h7E);
        expect_eq("inc_wrap_ac", 32'(lcd_bus.cursor_addr), 32'h00);
        wr4(0, 8'h85); wr4(0, 8'hB0);
        expect_eq("bad_addr_ac", 32'(lcd_bus.cursor_addr), 32'h00);
        wr4(0, 8'h10);
        expect_eq("shift_left_ac", 32'(lcd_bus.cursor_addr), 32'h67);
        wr4(0, 8'h14);
        expect_eq("shift_right_ac", 32'(lcd_bus.cursor_addr), 32'h00);
        wr4(0, 8'h0F);
        expect_eq("dcb_all", 32'({lcd_bus.disp_on, lcd_bus.cur_on, lcd_bus.blink_on}), 32'b111);

        // Back to 8-bit and into 4-bit again
        wr4(0, 8'h30);
        expect_eq("fs_8bit_mode4", 32'(lcd_bus.mode4), 0);
        nib(0, 0, 4'h2, 1);
        expect_eq("fs_4bit_mode4", 32'(lcd_bus.mode4), 1);
        expect_eq("fs_rx_byte", 32'(lcd_bus.rx_byte), 32'h20);

`ifdef LCD_RX_BUSY_EN
        expect_eq("busy_pre_err", 32'(lcd_bus.err_busy), 0);
        wr4(0, 8'h01);
        repeat (990) @(posedge clk);
        d0 = dv_cnt;
        nib(1, 0, 4'h3, 0); nib(1, 0, 4'h3, 0);
        expect_eq("busy_drop_err", 32'(lcd_bus.err_busy), 1);
        expect_eq("busy_drop_dv",  32'(dv_cnt - d0), 0);
        expect_eq("busy_still",    32'(lcd_bus.busy), 1);
        wr4(1, 8'h33);
        rd(7'h00, d); expect_eq("busy_accept_ddram", 32'(d), 32'h33);
        expect_eq("busy_accept_ac", 32'(lcd_bus.cursor_addr), 32'h01);
`endif

        // A fall during the clear sweep is dropped and flagged
        wr4(0, 8'h01);
        nib(1, 0, 4'h4, 0);
        repeat (100) @(posedge clk);
        wait_ready();
        expect_eq("clr_drop_err", 32'(lcd_bus.err_busy), 1);
        rd(7'h67, d); expect_eq("clr_ddram_67", 32'(d), 32'h20);
        wr4(1, 8'h42);
        rd(7'h00, d); expect_eq("clr_phase_ddram_00", 32'(d), 32'h42);
        expect_eq("clr_phase_ac", 32'(lcd_bus.cursor_addr), 32'h01);

        // Reset with a high nibble held
        nib(0, 0, 4'h8, 1);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        expect_eq("mid_rst_mode4", 32'(lcd_bus.mode4), 0);
        expect_eq("mid_rst_ac",    32'(lcd_bus.cursor_addr), 0);
        expect_eq("mid_rst_err",   32'(lcd_bus.err_busy), 0);
        expect_eq("mid_rst_dcb",   32'({lcd_bus.disp_on, lcd_bus.cur_on, lcd_bus.blink_on}), 0);
        expect_eq("mid_rst_rx",    32'(lcd_bus.rx_byte), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        c0 = cv_cnt;
        @(posedge clk); #1;
        lcd_bus.LCD_RS = 1'b0; lcd_bus.LCD_RW = 1'b0; lcd_bus.LCD_DB = 4'h4; lcd_bus.LCD_E = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_bus.LCD_E = 1'b0;
        @(negedge clk); @(negedge clk);
        expect_eq("lat_detect_cycle", 32'(lcd_bus.cmd_valid), 0);
        @(negedge clk);
        expect_eq("lat_exec_cycle", 32'(lcd_bus.cmd_valid), 1);
        @(negedge clk);
        expect_eq("lat_after_exec", 32'(lcd_bus.cmd_valid), 0);
        expect_eq("post_rst_rx_byte", 32'(lcd_bus.rx_byte), 32'h40);
        expect_eq("post_rst_mode4",   32'(lcd_bus.mode4), 0);
        expect_eq("post_rst_pulses",  32'(cv_cnt - c0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
